// File: rtl/y_wb_writer.sv
// y_wb_writer
// Write-back engine for the Y-matrix SRAM. Updated 48-bit complex entries
// {real[23:0], img[23:0]} arrive from the update datapath through a small
// input FIFO. Each one is committed to its packed slot with a
// read-modify-write of the 256-bit SRAM word.
//
// Packing: five entries per word. Slot k = col mod 5 occupies
// bits [48k+47:48k]. Bits [255:240] are reserved and carried through
// unchanged. The word address is row*WORDS_PER_ROW + col/5, truncated to
// 11 bits.
//
// Optional build macro YWB_COALESCE_EN: while the FSM is in WRITE, FIFO
// heads that hit the same word are folded into the write buffer, so one SRAM
// write covers several updates. Without the macro, every update does its own
// READ/MERGE/WRITE.

module y_wb_writer #(
   parameter int WORDS_PER_ROW = 4,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         wb_valid,
   output logic         wb_ready,
   input  logic [15:0]  wb_row,
   input  logic [15:0]  wb_col,
   input  logic [47:0]  wb_val,
   input  logic         wb_lastIn,
   output logic [10:0]  ymem_addr,
   output logic         ymem_rdEn,
   input  logic [255:0] ymem_rdData,
   output logic         ymem_wrEn,
   output logic [255:0] ymem_wrData,
   output logic         wb_allDone,
   output logic         wb_errFlag
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [15:0]      NUM_COLS = 16'(5 * WORDS_PER_ROW);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} stateType;

   // Replace one 48-bit slot of a word. The reserved top bits are untouched.
   function automatic logic [255:0] putSlot(input logic [255:0] word,
                                            input logic [2:0]   slot,
                                            input logic [47:0]  val);
      logic [255:0] res;
      res = word;
      for (int k = 0; k < 5; k++) begin
         if (slot == 3'(k)) res[48*k +: 48] = val;
      end
      return res;
   endfunction

   // FIFO storage and control
   logic [15:0]      fifoRow  [FIFO_DEPTH];
   logic [15:0]      fifoCol  [FIFO_DEPTH];
   logic [47:0]      fifoVal  [FIFO_DEPTH];
   logic             fifoLast [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;

   // Head-of-FIFO view and its decoded address/slot
   logic [15:0] headRow;
   logic [15:0] headCol;
   logic [47:0] headVal;
   logic        headLast;
   logic        headValid;
   logic        headColOk;
   logic [15:0] headWord;
   logic [2:0]  headSlot;
   logic [10:0] headAddr;

   // Working registers for the entry being written
   stateType    state;
   logic [2:0]  workSlot;
   logic [47:0] workVal;
   logic        workLast;

   assign wb_ready  = (count != FULL_CNT);
   assign push      = wb_valid && wb_ready;

   assign headRow   = fifoRow[rdPtr];
   assign headCol   = fifoCol[rdPtr];
   assign headVal   = fifoVal[rdPtr];
   assign headLast  = fifoLast[rdPtr];
   assign headValid = (count != '0);
   assign headColOk = (headCol < NUM_COLS);
   assign headWord  = headCol / 16'd5;
   assign headSlot  = 3'(headCol % 16'd5);
   // Truncation to 11 bits commutes with multiply/add, so do it in 11 bits.
   assign headAddr  = 11'(headRow) * 11'(WORDS_PER_ROW) + 11'(headWord);

`ifdef YWB_COALESCE_EN
   logic headMatch;
   assign headMatch = headValid && headColOk && (headAddr == ymem_addr);
`endif

   // Pop decision: IDLE takes any head; WRITE takes the next head (or, while
   // coalescing, only a head that hits the word being built).
   always_comb begin
      pop = 1'b0;
      case (state)
         IDLE:  pop = headValid;
`ifdef YWB_COALESCE_EN
         WRITE: pop = ymem_wrEn ? headValid : headMatch;
`else
         WRITE: pop = headValid;
`endif
         default: pop = 1'b0;
      endcase
   end

   // FIFO entry storage; flushing is done by resetting the pointers.
   always_ff @(posedge clock) begin
      if (push) begin
         fifoRow[wrPtr]  <= wb_row;
         fifoCol[wrPtr]  <= wb_col;
         fifoVal[wrPtr]  <= wb_val;
         fifoLast[wrPtr] <= wb_lastIn;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + PTR_W'(1);
         if (pop)  rdPtr <= rdPtr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Read-modify-write FSM with registered SRAM strobes and status outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         ymem_addr   <= '0;
         ymem_rdEn   <= 1'b0;
         ymem_wrEn   <= 1'b0;
         ymem_wrData <= '0;
         wb_allDone  <= 1'b0;
         wb_errFlag  <= 1'b0;
         workSlot    <= '0;
         workVal     <= '0;
         workLast    <= 1'b0;
      end else begin
         ymem_rdEn  <= 1'b0;
         ymem_wrEn  <= 1'b0;
         wb_allDone <= 1'b0;
         case (state)
            IDLE: begin
               if (headValid) begin
                  if (headColOk) begin
                     ymem_addr <= headAddr;
                     workSlot  <= headSlot;
                     workVal   <= headVal;
                     workLast  <= headLast;
                     ymem_rdEn <= 1'b1;
                     state     <= READ;
                  end else begin
                     // Out-of-range column: drop it without touching the SRAM.
                     wb_errFlag <= 1'b1;
                     wb_allDone <= headLast;
                  end
               end
            end

            READ: begin
               state <= MERGE;
            end

            MERGE: begin
               ymem_wrData <= putSlot(ymem_rdData, workSlot, workVal);
`ifdef YWB_COALESCE_EN
               // Hold the write back if the next head belongs to this word.
               ymem_wrEn   <= !headMatch;
`else
               ymem_wrEn   <= 1'b1;
`endif
               state       <= WRITE;
            end

            WRITE: begin
`ifdef YWB_COALESCE_EN
               if (!ymem_wrEn) begin
                  if (headMatch) begin
                     ymem_wrData <= putSlot(ymem_wrData, headSlot, headVal);
                     workLast    <= workLast | headLast;
                  end else begin
                     ymem_wrEn <= 1'b1;
                  end
               end else
`endif
               begin
                  wb_allDone <= workLast;
                  if (headValid) begin
                     if (headColOk) begin
                        ymem_addr <= headAddr;
                        workSlot  <= headSlot;
                        workVal   <= headVal;
                        workLast  <= headLast;
                        ymem_rdEn <= 1'b1;
                        state     <= READ;
                     end else begin
                        wb_errFlag <= 1'b1;
                        wb_allDone <= workLast | headLast;
                        state      <= IDLE;
                     end
                  end else begin
                     state <= IDLE;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_y_wb_writer.sv
// Testbench for y_wb_writer: a behavioural SRAM plus an update-level model.
// The model is a queue of accepted in-range updates and an image of what the
// SRAM must contain, checked on every read/write strobe.

module tb_y_wb_writer;

   localparam int WPR   = 4;
   localparam int DEPTH = 4;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         wb_valid = 1'b0;
   logic         wb_ready;
   logic [15:0]  wb_row = '0;
   logic [15:0]  wb_col = '0;
   logic [47:0]  wb_val = '0;
   logic         wb_lastIn = 1'b0;
   logic [10:0]  ymem_addr;
   logic         ymem_rdEn;
   logic [255:0] ymem_rdData;
   logic         ymem_wrEn;
   logic [255:0] ymem_wrData;
   logic         wb_allDone;
   logic         wb_errFlag;

   y_wb_writer #(.WORDS_PER_ROW(WPR), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_row(wb_row), .wb_col(wb_col), .wb_val(wb_val), .wb_lastIn(wb_lastIn),
      .ymem_addr(ymem_addr), .ymem_rdEn(ymem_rdEn), .ymem_rdData(ymem_rdData),
      .ymem_wrEn(ymem_wrEn), .ymem_wrData(ymem_wrData),
      .wb_allDone(wb_allDone), .wb_errFlag(wb_errFlag)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Bench SRAM: one-cycle read latency
   logic [255:0] sram [0:2047];
   logic         clrAll = 1'b0;
   logic         preEn = 1'b0;
   logic [10:0]  preAddr = '0;
   logic [255:0] preData = '0;

   always @(posedge clock) begin
      if (clrAll) begin
         for (int i = 0; i < 2048; i++) sram[i] <= '0;
      end else if (preEn) begin
         sram[preAddr] <= preData;
      end
      if (ymem_rdEn) ymem_rdData <= sram[ymem_addr];
      if (ymem_wrEn) sram[ymem_addr] <= ymem_wrData;
   end

   // Model state
   typedef struct {
      logic [10:0] addr;
      int          slot;
      logic [47:0] val;
   } updT;

   updT          expQ [$];
   logic [255:0] refMem [0:2047];
   int           wrCycles [$];
   int nCmp = 0;
   int nFail = 0;
   int rdCnt = 0;
   int wrCnt = 0;
   int doneCnt = 0;
   int lastWrCyc = 0;
   int lastDoneCyc = 0;
   bit sawNotReady = 1'b0;
   bit sawBadCol = 1'b0;

   function automatic logic [255:0] putSlot(input logic [255:0] w, input int k,
                                            input logic [47:0] v);
      logic [255:0] r;
      r = w;
      r[48*k +: 48] = v;
      return r;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      nCmp++;
      if (act !== req) begin
         nFail++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Per-cycle compare against the update-level model
   task automatic monitor();
      updT          e;
      updT          n;
      logic [255:0] w;
      forever begin
         @(negedge clock);
         if (reset) begin
            expQ.delete();
         end else begin
            if (!wb_ready) sawNotReady = 1'b1;
            if (ymem_rdEn || ymem_wrEn)
               chk("rd_wr_exclusive", 256'(ymem_rdEn & ymem_wrEn), 256'(0));
            if (ymem_rdEn) begin
               rdCnt++;
               chk("read_pending", 256'(expQ.size() != 0), 256'(1));
               if (expQ.size() != 0) chk("read_addr", 256'(ymem_addr), 256'(expQ[0].addr));
            end
            if (ymem_wrEn) begin
               wrCnt++;
               lastWrCyc = cyc;
               wrCycles.push_back(cyc);
               chk("write_pending", 256'(expQ.size() != 0), 256'(1));
               if (expQ.size() != 0) begin
                  e = expQ.pop_front();
                  w = putSlot(refMem[e.addr], e.slot, e.val);
`ifdef YWB_COALESCE_EN
                  while (expQ.size() != 0 && expQ[0].addr == e.addr && w != ymem_wrData) begin
                     n = expQ.pop_front();
                     w = putSlot(w, n.slot, n.val);
                  end
`endif
                  chk("write_addr", 256'(ymem_addr), 256'(e.addr));
                  chk("write_data", ymem_wrData, w);
                  refMem[e.addr] = w;
               end
            end
            if (wb_allDone) begin
               doneCnt++;
               lastDoneCyc = cyc;
            end
            if (wb_valid && wb_ready) begin
               if (int'(wb_col) < 5 * WPR) begin
                  e.addr = 11'(int'(wb_row) * WPR + int'(wb_col) / 5);
                  e.slot = int'(wb_col) % 5;
                  e.val  = wb_val;
                  expQ.push_back(e);
               end else begin
                  sawBadCol = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic offer(input logic [15:0] r, input logic [15:0] c,
                        input logic [47:0] v, input logic l);
      int waitCnt;
      waitCnt = 0;
      wb_valid = 1'b1;
      wb_row = r;
      wb_col = c;
      wb_val = v;
      wb_lastIn = l;
      while (!wb_ready && waitCnt < 50) begin
         tick();
         waitCnt++;
      end
      if (waitCnt >= 50) chk("offer_accept", 256'(wb_ready), 256'(1));
      tick();
      wb_valid = 1'b0;
      wb_lastIn = 1'b0;
   endtask

   task automatic preload(input logic [10:0] a, input logic [255:0] d);
      preAddr = a;
      preData = d;
      preEn = 1'b1;
      refMem[a] = d;
      tick();
      preEn = 1'b0;
   endtask

   logic [255:0] expWord;
   logic [255:0] base;
   logic [47:0]  valA;
   logic [47:0]  valB;
   int           doneB;
   int           rdB;
   int           wrB;
   int           diffWords;

   initial begin
      fork
         monitor();
      join_none

      // Reset and clear memories
      for (int i = 0; i < 2048; i++) refMem[i] = '0;
      clrAll = 1'b1;
      tick();
      clrAll = 1'b0;
      tick();
      chk("reset_ready",   256'(wb_ready),   256'(1));
      chk("reset_addr",    256'(ymem_addr),  256'(0));
      chk("reset_rdEn",    256'(ymem_rdEn),  256'(0));
      chk("reset_wrEn",    256'(ymem_wrEn),  256'(0));
      chk("reset_wrData",  ymem_wrData,      256'(0));
      chk("reset_allDone", 256'(wb_allDone), 256'(0));
      chk("reset_errFlag", 256'(wb_errFlag), 256'(0));
      reset = 1'b0;
      tick();

      // Single update: row 3, col 7 -> word 13, slot 2
      preload(11'd13, '1);
      offer(16'd3, 16'd7, 48'hABCDEF_123456, 1'b1);
      chk("single_rdEn_c1", 256'(ymem_rdEn), 256'(0));
      tick();
      chk("single_rdEn_c2", 256'(ymem_rdEn), 256'(1));
      chk("single_addr_c2", 256'(ymem_addr), 256'(13));
      tick();
      chk("single_wrEn_c3", 256'(ymem_wrEn), 256'(0));
      tick();
      expWord = '1;
      expWord[143:96] = 48'hABCDEF_123456;
      chk("single_wrEn_c4", 256'(ymem_wrEn), 256'(1));
      chk("single_wrData_c4", ymem_wrData, expWord);
      tick();
      chk("single_done_c5", 256'(wb_allDone), 256'(1));
      tick();
      chk("single_done_c6", 256'(wb_allDone), 256'(0));

      // Same word then last: (0,0) then (0,1)
      doneB = doneCnt;
      wrB = wrCnt;
      valA = 48'h111111_222222;
      valB = 48'h333333_444444;
      offer(16'd0, 16'd0, valA, 1'b0);
      offer(16'd0, 16'd1, valB, 1'b1);
      repeat (14) tick();
`ifdef YWB_COALESCE_EN
      chk("sameword_writes", 256'(wrCnt - wrB), 256'(1));
`else
      chk("sameword_writes", 256'(wrCnt - wrB), 256'(2));
`endif
      chk("sameword_done_cnt", 256'(doneCnt - doneB), 256'(1));
      chk("sameword_done_time", 256'(lastDoneCyc), 256'(lastWrCyc + 1));
      chk("sameword_slot0", 256'(sram[0][47:0]), 256'(valA));
      chk("sameword_slot1", 256'(sram[0][95:48]), 256'(valB));

      // Burst of six distinct words, offered back to back
      sawNotReady = 1'b0;
      wrCycles.delete();
      for (int i = 0; i < 6; i++)
         offer(16'(10 + i), 16'(i), 48'({$urandom(), $urandom()}), 1'b0);
      repeat (25) tick();
      chk("burst_ready_drop", 256'(sawNotReady), 256'(1));
      chk("burst_writes", 256'(wrCycles.size()), 256'(6));
      for (int i = 1; i < wrCycles.size(); i++)
         chk("burst_spacing", 256'(wrCycles[i] - wrCycles[i-1]), 256'(3));

      // Reserved bits preserved: row 7, col 4 -> word 28, slot 4
      for (int i = 0; i < 8; i++) base[32*i +: 32] = $urandom();
      preload(11'd28, {16'hBEEF, base[239:0]});
      valA = 48'h0F0F0F_A5A5A5;
      offer(16'd7, 16'd4, valA, 1'b0);
      repeat (10) tick();
      chk("reserved_word", sram[28], {16'hBEEF, valA, base[191:0]});

      // Out-of-range column with last set
      doneB = doneCnt;
      rdB = rdCnt;
      wrB = wrCnt;
      offer(16'd1, 16'd20, 48'h123456_789ABC, 1'b1);
      repeat (8) tick();
      chk("oor_no_read", 256'(rdCnt), 256'(rdB));
      chk("oor_no_write", 256'(wrCnt), 256'(wrB));
      chk("oor_errFlag", 256'(wb_errFlag), 256'(1));
      chk("oor_done", 256'(doneCnt - doneB), 256'(1));
      repeat (5) tick();
      chk("oor_errFlag_sticky", 256'(wb_errFlag), 256'(1));

      // Reset asserted during READ
      wrB = wrCnt;
      offer(16'd5, 16'd2, 48'hDEADBE_EF0123, 1'b0);
      tick();
      chk("rst_read_rdEn", 256'(ymem_rdEn), 256'(1));
      chk("rst_read_addr", 256'(ymem_addr), 256'(20));
      #2 reset = 1'b1;
      #1;
      chk("rst_async_rdEn",    256'(ymem_rdEn),  256'(0));
      chk("rst_async_wrEn",    256'(ymem_wrEn),  256'(0));
      chk("rst_async_addr",    256'(ymem_addr),  256'(0));
      chk("rst_async_wrData",  ymem_wrData,      256'(0));
      chk("rst_async_errFlag", 256'(wb_errFlag), 256'(0));
      chk("rst_async_allDone", 256'(wb_allDone), 256'(0));
      chk("rst_async_ready",   256'(wb_ready),   256'(1));
      tick();
      reset = 1'b0;
      repeat (10) tick();
      chk("rst_no_write", 256'(wrCnt), 256'(wrB));
      chk("rst_ready", 256'(wb_ready), 256'(1));

      // Randomized traffic over a few words, including bad columns
      sawBadCol = 1'b0;
      doneB = doneCnt;
      for (int i = 0; i < 300; i++) begin
         wb_valid = ($urandom_range(0, 9) < 6);
         wb_row = 16'($urandom_range(0, 3));
         wb_col = 16'($urandom_range(0, 21));
         wb_val = 48'({$urandom(), $urandom()});
         wb_lastIn = 1'b0;
         tick();
      end
      wb_valid = 1'b0;
      repeat (60) tick();
      chk("random_drained", 256'(expQ.size()), 256'(0));
      diffWords = 0;
      for (int a = 0; a < 64; a++)
         if (sram[a] !== refMem[a]) diffWords++;
      chk("random_sram_image", 256'(diffWords), 256'(0));
      chk("random_no_done", 256'(doneCnt), 256'(doneB));
      chk("random_errFlag", 256'(wb_errFlag), 256'(sawBadCol));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule

// File: doc/y_wb_writer.md
# y_wb_writer

Write-back engine for the Y-matrix SRAM. It accepts updated 48-bit complex Y entries from the update datapath and performs a read-modify-write into the 256-bit-wide Y SRAM. The read side of the Y-update pipeline fetches rows and computes new values; this block is the matching writer that commits each value to its packed slot. A small input FIFO absorbs bursts from the datapath.

## Interface
- `WORDS_PER_ROW`, default 4: SRAM words per matrix row. Valid columns are 0 to 5·WORDS_PER_ROW−1.
- `FIFO_DEPTH`, default 4: input FIFO entries. Must be a power of 2 and at least 2.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `wb_valid` in 1: an update is offered.
- `wb_ready` out 1: FIFO not full. Reset value 1.
- `wb_row` in 16: matrix row.
- `wb_col` in 16: matrix column.
- `wb_val` in 48: {real[23:0], img[23:0]}.
- `wb_lastIn` in 1: marks the final update of a change set. Stored with the entry.
- `ymem_addr` out 11: SRAM word address. Reset value 0.
- `ymem_rdEn` out 1: SRAM read strobe. Reset value 0.
- `ymem_rdData` in 256: read data, valid 1 cycle after `ymem_rdEn`.
- `ymem_wrEn` out 1: SRAM write strobe. Reset value 0.
- `ymem_wrData` out 256: write data. Reset value 0.
- `wb_allDone` out 1: one-cycle pulse when the last-marked update has been committed or dropped. Reset value 0.
- `wb_errFlag` out 1: sticky flag for an out-of-range column. Reset value 0.

## Operation
- **Packing:** each SRAM word holds 5 entries. Slot k = col mod 5 occupies bits [48k+47:48k]. Bits [255:240] are reserved and are always written back unchanged.
- **Address:** (row·WORDS_PER_ROW + col/5), truncated to 11 bits. col/5 and col mod 5 are computed combinationally.
- **FIFO:** a push occurs on `wb_valid && wb_ready`. Each entry stores {row, col, val, last}. `wb_ready = !full`.
- **FSM states:** IDLE, READ, MERGE, WRITE.
  - IDLE: if the FIFO is non-empty, pop the head into working registers and go to READ.
  - READ: assert `ymem_rdEn` and drive `ymem_addr`. Go to MERGE.
  - MERGE: capture `ymem_rdData` into the write buffer with the target slot replaced by the working value. Go to WRITE.
  - WRITE: assert `ymem_wrEn` and drive `ymem_addr` and `ymem_wrData`. If the FIFO is non-empty, pop and go to READ; otherwise go to IDLE.
- **Out-of-range column:** an entry with col ≥ 5·WORDS_PER_ROW is discarded at pop. There is no SRAM access, `wb_errFlag` is set, and the FSM stays in or returns to IDLE.
- **Done pulse:** `wb_allDone` pulses in the cycle after the WRITE, or the cycle after the drop, of an entry whose last bit is set.
- **Reset mid-operation:** the FIFO is flushed, the FSM goes to IDLE and no pending write is issued. The SRAM may hold any word already written.

## Timing
- An update accepted in cycle 0 with the FIFO empty and the FSM in IDLE produces this sequence:
  - pop in cycle 1,
  - `ymem_rdEn` in cycle 2,
  - merge in cycle 3,
  - `ymem_wrEn` in cycle 4.
- Steady-state throughput is one update per 3 cycles (WRITE→READ back-to-back).
- `ymem_*` outputs are Moore outputs, decoded from state plus registers. `ymem_rdEn` and `ymem_wrEn` are never high in the same cycle.
- **Full FIFO with a pop in the same cycle:** `wb_ready` is still 0 that cycle. No push occurs.
- A push into an empty FIFO is not visible to IDLE until the following cycle.

## Configuration
- **`YWB_COALESCE_EN` defined:**
  - In WRITE, if the FIFO head maps to the same word address and has a valid column, the head is popped and merged into the write buffer. WRITE repeats with `ymem_wrEn` held low.
  - The write is issued only once no further same-word head is present.
  - The last bit is OR-ed into the buffer.
- **`YWB_COALESCE_EN` not defined:** every update performs its own full READ/MERGE/WRITE, even when consecutive updates hit the same word.

## Test plan
- **Single update:** row=3, col=7, val=48'hABCDEF_123456, SRAM word 13 preloaded with all 1s.
  - Response: `ymem_rdEn` with addr 13 in cycle 2.
  - Response: `ymem_wrEn` in cycle 4 with bits [143:96]=48'hABCDEF_123456 and all other bits 1.
- **Burst:** 6 back-to-back offers.
  - Response: `wb_ready` drops after the FIFO fills.
  - Response: all 6 writes occur, in order, 3 cycles apart.
  - Response: no entry is lost or duplicated.
- **Same word, then last:** updates to (0,0) then (0,1) with last=1.
  - Without the macro: two writes to addr 0, and the second contains both values.
  - With the macro: a single write to addr 0 with both slots updated.
  - Both configurations: `wb_allDone` pulses once, in the cycle after the final write.
- **Out of range:** col=20 with last=1 at WORDS_PER_ROW=4.
  - Response: no `ymem_rdEn` or `ymem_wrEn`.
  - Response: `wb_errFlag`=1 and stays 1.
  - Response: `wb_allDone` pulses.
- **Reset in READ:** assert `reset` during the READ cycle.
  - Response: all outputs return to their reset values immediately (asynchronous).
  - Response: no `ymem_wrEn` ever follows, and `wb_ready`=1.
- **Reserved bits:** preload bits [255:240]=16'hBEEF, then update col=4.
  - Response: the written word keeps 16'hBEEF in [255:240] and slot 4 in [239:192] is updated.
